diff_fold_residual: RTL and testbench
=====================================

DIFF_FOLD_RESIDUAL -- requirements
Module: diff_fold_residual

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of the modulo sample input and the residual output.
REQ-002 SHALL have parameter LAMBDA, default 10, modulo threshold; the fold period is 2*LAMBDA.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_in  input  1  qualifies y_in for one cycle.
REQ-006 SHALL have port y_in  input  WIDTH signed  modulo sample y[k], legal range [-LAMBDA, LAMBDA).
REQ-007 SHALL have port valid_out  output  1  one-cycle pulse qualifying residual_diff_out.
REQ-008 SHALL have port residual_diff_out  output  WIDTH signed  second-order residual difference, fed directly to the anti-difference/rounding stage.
REQ-009 SHALL have port range_err  output  1  sticky flag: an out-of-range y_in was accepted.

Function
REQ-010 SHALL accept a sample on every rising edge where valid_in=1; no backpressure is provided.
REQ-011 SHALL keep a two-deep history y[k-1], y[k-2] that updates only on accepted samples; it holds when valid_in=0.
REQ-012 SHALL track warm-up with states FILL0 -> FILL1 -> RUN, advancing one state per accepted sample; RUN is absorbing until reset.
REQ-013 SHALL produce no valid_out for the samples accepted in FILL0 and FILL1; every sample accepted in RUN produces exactly one valid_out pulse.
REQ-014 Stage 1 SHALL register d2 = y[k] - 2*y[k-1] + y[k-2] at internal width WIDTH+3 with no overflow.
REQ-015 Stage 2 SHALL compute the centred fold M(d2) = ((d2 + LAMBDA) mod 2*LAMBDA) - LAMBDA, with floor modulo so that M is in [-LAMBDA, LAMBDA).
REQ-016 SHALL implement the fold by subtracting k*2*LAMBDA, k in {-2..2}, chosen by comparison; no divider.
REQ-017 SHALL register residual_diff_out = M(d2) - d2, which is always a multiple of 2*LAMBDA in {-4L, -2L, 0, 2L, 4L} (L = LAMBDA).
REQ-018 Latency: for a RUN sample accepted at edge n, residual_diff_out and valid_out SHALL be updated at edge n+2; valid_out is high for exactly that one cycle.
REQ-019 SHALL sustain back-to-back valid_in (one result per cycle).
REQ-020 Gaps in valid_in SHALL propagate as gaps in valid_out; the pipeline SHALL NOT reorder or duplicate results.
REQ-021 residual_diff_out SHALL hold its last value while valid_out=0.
REQ-022 range_err SHALL set on the edge that accepts a y_in outside [-LAMBDA, LAMBDA) and stay set until reset.
REQ-023 Processing of an out-of-range sample SHALL continue using the raw value.
REQ-024 Boundary: d2 = +LAMBDA SHALL fold to -LAMBDA; d2 = -LAMBDA SHALL fold to -LAMBDA (residual 0).

Reset
REQ-025 On reset=1 at a rising edge, the block SHALL clear the history, pipeline registers, residual_diff_out, valid_out and range_err to 0, and set the state to FILL0.
REQ-026 Reset asserted mid-stream SHALL discard in-flight results: no valid_out on the edge after reset deasserts, and the next two accepted samples are warm-up again.
REQ-027 valid_in SHALL be ignored on any edge where reset=1.

Verification (LAMBDA=10, WIDTH=16)
REQ-028 Warm-up and fold: y_in = 0, 5, -8 on consecutive cycles -> exactly one valid_out, two edges after -8 is accepted, with residual_diff_out = 20.
REQ-029 Large wrap: y_in = 9, -9, 9 -> residual_diff_out = -40; then a fourth sample -9 (d2 = -36) -> residual_diff_out = +40 on the next cycle.
REQ-030 Fold boundaries: y_in = 0, -5, 0 -> d2 = 10 -> residual_diff_out = -20; y_in = 0, 5, 0 -> d2 = -10 -> residual_diff_out = 0.
REQ-031 Gapped input: 0, 0, 3 with two idle cycles before 3 -> history holds across the gaps; single valid_out with residual_diff_out = 0; no other pulses.
REQ-032 Range and reset: y_in = 10 accepted -> range_err = 1 on the next cycle; reset pulse -> range_err = 0, and valid_out stays low for the next two accepted samples.

Source files
------------

// File: rtl/diff_fold_residual.sv
// -----------------------------------------------------------------------------
// diff_fold_residual
//
// Purpose:
//   Forms the second-order difference of a stream of modulo samples and
//   returns the residual between its centred fold and the raw difference:
//     d2       = y[k] - 2*y[k-1] + y[k-2]
//     M(d2)    = ((d2 + LAMBDA) mod 2*LAMBDA) - LAMBDA   (floor modulo)
//     residual = M(d2) - d2                              (multiple of 2*LAMBDA)
//   The first two samples after reset only fill the history. Every later
//   sample produces one result two edges after it is accepted.
//
// Parameters:
//   WIDTH   sample / residual width (signed)
//   LAMBDA  modulo threshold; the fold period is 2*LAMBDA
//
// Ports:
//   clk                input   rising-edge clock
//   reset              input   synchronous, active-high reset
//   valid_in           input   qualifies y_in for one cycle (no backpressure)
//   y_in               input   signed modulo sample, legal range [-LAMBDA, LAMBDA)
//   valid_out          output  one-cycle pulse qualifying residual_diff_out
//   residual_diff_out  output  signed residual, holds while valid_out = 0
//   range_err          output  sticky: an out-of-range sample was accepted
// -----------------------------------------------------------------------------
module diff_fold_residual #(
    parameter int WIDTH  = 16,
    parameter int LAMBDA = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] residual_diff_out,
    output logic                    range_err
);

    // Three extra bits hold |d2| <= 4 * 2^(WIDTH-1) for any raw input.
    localparam int D_W = WIDTH + 3;

    localparam logic [1:0] S_FILL0 = 2'd0;
    localparam logic [1:0] S_FILL1 = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    localparam logic signed [D_W-1:0]   C_L   = D_W'(LAMBDA);
    localparam logic signed [D_W-1:0]   C_NL  = D_W'(-LAMBDA);
    localparam logic signed [D_W-1:0]   C_3L  = D_W'(3 * LAMBDA);
    localparam logic signed [D_W-1:0]   C_N3L = D_W'(-3 * LAMBDA);
    localparam logic signed [D_W-1:0]   C_2L  = D_W'(2 * LAMBDA);
    localparam logic signed [D_W-1:0]   C_4L  = D_W'(4 * LAMBDA);
    localparam logic signed [WIDTH-1:0] C_LO  = WIDTH'(-LAMBDA);
    localparam logic signed [WIDTH-1:0] C_HI  = WIDTH'(LAMBDA);

    // Warm-up state and sample history
    logic [1:0]              r_state;
    logic signed [WIDTH-1:0] r_y1;
    logic signed [WIDTH-1:0] r_y2;

    // Stage 1: raw second difference
    logic signed [D_W-1:0]   r_d2_s1;
    logic                    r_v1;

    // Stage 2: folded value alongside the raw difference it came from
    logic signed [D_W-1:0]   r_d2_s2;
    logic signed [D_W-1:0]   r_fold_s2;
    logic                    r_v2;

    logic signed [D_W-1:0]   w_y0_x;
    logic signed [D_W-1:0]   w_y1_x;
    logic signed [D_W-1:0]   w_y2_x;
    logic signed [D_W-1:0]   w_d2;
    logic signed [D_W-1:0]   w_fold;
    logic signed [D_W-1:0]   w_res;
    logic                    w_out_of_range;

    assign w_y0_x = {{3{y_in[WIDTH-1]}}, y_in};
    assign w_y1_x = {{3{r_y1[WIDTH-1]}}, r_y1};
    assign w_y2_x = {{3{r_y2[WIDTH-1]}}, r_y2};
    assign w_d2   = w_y0_x - (w_y1_x + w_y1_x) + w_y2_x;

    assign w_out_of_range = (y_in < C_LO) || (y_in >= C_HI);

    // Centred fold: subtract k*2L where k = floor((d2 + L) / 2L), found by
    // comparing against the odd multiples of L. Legal inputs keep k in -2..2.
    // NOTE: the default assignment first means every path writes w_fold, so no latch is inferred.
    always_comb begin
        w_fold = r_d2_s1;
        if (r_d2_s1 >= C_3L) begin
            w_fold = r_d2_s1 - C_4L;
        end else if (r_d2_s1 >= C_L) begin
            w_fold = r_d2_s1 - C_2L;
        end else if (r_d2_s1 >= C_NL) begin
            w_fold = r_d2_s1;
        end else if (r_d2_s1 >= C_N3L) begin
            w_fold = r_d2_s1 + C_2L;
        end else begin
            w_fold = r_d2_s1 + C_4L;
        end
    end

    assign w_res = r_fold_s2 - r_d2_s2;

    // NOTE: non-blocking assignments let every stage read the previous-cycle values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_FILL0;
            r_y1              <= '0;
            r_y2              <= '0;
            r_d2_s1           <= '0;
            r_v1              <= 1'b0;
            r_d2_s2           <= '0;
            r_fold_s2         <= '0;
            r_v2              <= 1'b0;
            valid_out         <= 1'b0;
            residual_diff_out <= '0;
            range_err         <= 1'b0;
        end else begin
            // Accept stage: history, warm-up tracking and range flag
            r_v1 <= 1'b0;
            if (valid_in) begin
                r_y1 <= y_in;
                r_y2 <= r_y1;
                if (w_out_of_range) begin
                    range_err <= 1'b1;
                end
                case (r_state)
                    S_FILL0: r_state <= S_FILL1;
                    S_FILL1: r_state <= S_RUN;
                    default: r_state <= S_RUN;
                endcase
                if (r_state == S_RUN) begin
                    r_d2_s1 <= w_d2;
                    r_v1    <= 1'b1;
                end
            end

            // Fold stage
            r_v2 <= r_v1;
            if (r_v1) begin
                r_d2_s2   <= r_d2_s1;
                r_fold_s2 <= w_fold;
            end

            // Output stage: residual is a small multiple of 2L, so it fits WIDTH
            valid_out <= r_v2;
            if (r_v2) begin
                residual_diff_out <= w_res[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_diff_fold_residual.sv
// -----------------------------------------------------------------------------
// tb_diff_fold_residual
//
// Purpose:
//   Self-checking bench for diff_fold_residual (WIDTH=16, LAMBDA=10).
//   A reference model forms each expected residual from the fold definition
//   using integer floor modulo, and schedules it in a queue tagged with the
//   edge on which it must appear. Outputs are compared every cycle on the
//   falling edge; inputs change on the falling edge after comparison.
// -----------------------------------------------------------------------------
module tb_diff_fold_residual;

    localparam int WIDTH  = 16;
    localparam int LAMBDA = 10;

    logic                    clk;
    logic                    reset;
    logic                    valid_in;
    logic signed [WIDTH-1:0] y_in;
    logic                    valid_out;
    logic signed [WIDTH-1:0] residual_diff_out;
    logic                    range_err;

    diff_fold_residual #(
        .WIDTH  (WIDTH),
        .LAMBDA (LAMBDA)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .valid_in          (valid_in),
        .y_in              (y_in),
        .valid_out         (valid_out),
        .residual_diff_out (residual_diff_out),
        .range_err         (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "init";

    task automatic check(input string tag, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s/%s: got %0d, expected %0d (t=%0t)", phase, tag, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        int t;
        int res;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   m_h1   = 0;
    int   m_h2   = 0;
    int   m_n    = 0;
    int   m_res  = 0;
    logic m_rerr = 1'b0;

    // Residual straight from the definition: centred floor-modulo fold minus d2
    function automatic int fold_res(input int d2);
        int p;
        int m;
        p = 2 * LAMBDA;
        m = (d2 + LAMBDA) % p;
        if (m < 0) m += p;
        return (m - LAMBDA) - d2;
    endfunction

    task automatic step(input logic rst, input logic v, input int y);
        exp_t e;
        logic exp_v;
        reset    = rst;
        valid_in = v;
        y_in     = y[WIDTH-1:0];
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            m_h1   = 0;
            m_h2   = 0;
            m_n    = 0;
            m_res  = 0;
            m_rerr = 1'b0;
        end else if (v) begin
            if (y < -LAMBDA || y >= LAMBDA) m_rerr = 1'b1;
            if (m_n >= 2) begin
                e.t   = cyc + 2;
                e.res = fold_res(y - 2 * m_h1 + m_h2);
                q.push_back(e);
            end
            m_h2 = m_h1;
            m_h1 = y;
            m_n++;
        end
        @(negedge clk);
        exp_v = 1'b0;
        if (q.size() > 0 && q[0].t == cyc) begin
            exp_v = 1'b1;
            m_res = q[0].res;
            void'(q.pop_front());
        end
        check("valid_out", {31'd0, valid_out}, {31'd0, exp_v});
        check("residual", 32'(residual_diff_out), 32'(m_res));
        check("range_err", {31'd0, range_err}, {31'd0, m_rerr});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 7);  // valid_in is high but must be ignored
        step(1'b1, 1'b0, 0);
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        y_in     = '0;
        @(negedge clk);

        phase = "reset";
        do_reset();
        idle(2);

        phase = "warmup";             // d2 = -18 -> +20
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 5);
        step(1'b0, 1'b1, -8);
        idle(4);

        phase = "large_wrap";         // d2 = 36 -> -40, then d2 = -36 -> +40
        do_reset();
        step(1'b0, 1'b1, 9);
        step(1'b0, 1'b1, -9);
        step(1'b0, 1'b1, 9);
        step(1'b0, 1'b1, -9);
        idle(4);

        phase = "bound_hi";           // d2 = +10 -> -20
        do_reset();
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, -5);
        step(1'b0, 1'b1, 0);
        idle(4);

        phase = "bound_lo";           // d2 = -10 -> 0
        do_reset();
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 5);
        step(1'b0, 1'b1, 0);
        idle(4);

        phase = "gapped";             // history holds across idle cycles
        do_reset();
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        idle(2);
        step(1'b0, 1'b1, 3);
        idle(4);

        phase = "range_reset";        // range_err sets, reset clears, warm-up repeats
        step(1'b0, 1'b1, 10);
        idle(3);
        step(1'b0, 1'b1, 4);
        do_reset();
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b1, -3);
        idle(3);
        step(1'b0, 1'b1, -11);        // below range, processed with raw value
        idle(4);

        phase = "midstream_reset";    // in-flight results are discarded
        do_reset();
        step(1'b0, 1'b1, 1);
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b1, 3);
        step(1'b0, 1'b1, 4);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 5);
        step(1'b0, 1'b1, 6);
        step(1'b0, 1'b1, -7);
        idle(4);

        phase = "random";
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic v;
            int   y;
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 4)
                y = ($urandom_range(0, 1) == 1) ? LAMBDA : -LAMBDA - 1;
            else
                y = int'($urandom_range(0, 2 * LAMBDA - 1)) - LAMBDA;
            step(r, v, y);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
